// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and helpers for alu_seq_core.
// FSM encodings, funct3 codes, opcodes and op_code field slices.
package alu_pkg;

   typedef logic [1:0] state_e;

   localparam state_e ST_IDLE    = 2'd0;
   localparam state_e ST_COLLECT = 2'd1;
   localparam state_e ST_EXEC    = 2'd2;
   localparam state_e ST_DONE    = 2'd3;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] OPC_R = 7'b0110011;
   localparam logic [6:0] OPC_I = 7'b0010011;

   function automatic logic [6:0] op_opc(input logic [10:0] op);
      return op[6:0];
   endfunction

   function automatic logic [2:0] op_f3(input logic [10:0] op);
      return op[9:7];
   endfunction

   function automatic logic op_f7b5(input logic [10:0] op);
      return op[10];
   endfunction

endpackage

// File: rtl/alu_seq_core_shift.sv
// alu_shift_unit: SLL/SRL/SRA engine for alu_seq_core; barrel by default,
// one bit per cycle when ALU_SERIAL_SHIFT_EN is defined (start/busy/done).
module alu_shift_unit
   import alu_pkg::*;
#(
   parameter int BUS = 32,
   localparam int SHAMT_W = $clog2(BUS)
) (
`ifdef ALU_SERIAL_SHIFT_EN
   input  logic               clk,
   input  logic               rst_n,
`endif
   input  logic               start,
   input  logic               left,
   input  logic               arith,
   input  logic [BUS-1:0]     a,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [BUS-1:0]     result
);

`ifdef ALU_SERIAL_SHIFT_EN

   logic [BUS-1:0]     acc_q, acc_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;

   function automatic logic [BUS-1:0] step(
      input logic [BUS-1:0] x,
      input logic           l,
      input logic           ar
   );
      if (l) return {x[BUS-2:0], 1'b0};
      return {ar & x[BUS-1], x[BUS-1:1]};
   endfunction

   assign busy = (cnt_q != '0);

   // The first step happens in the start cycle, so shamt cycles in total;
   // shamt of 0 or 1 finishes in that same cycle.
   always_comb begin
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      done   = 1'b0;
      result = step(acc_q, left, arith);
      if (start) begin
         if (shamt <= SHAMT_W'(1)) begin
            done   = 1'b1;
            result = (shamt == '0) ? a : step(a, left, arith);
         end else begin
            acc_d = step(a, left, arith);
            cnt_d = shamt - SHAMT_W'(1);
         end
      end else if (busy) begin
         if (cnt_q == SHAMT_W'(1)) begin
            done  = 1'b1;
            cnt_d = '0;
         end else begin
            acc_d = step(acc_q, left, arith);
            cnt_d = cnt_q - SHAMT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

`else

   logic [BUS-1:0] sra;

   // Kept apart so the arithmetic shift stays in a signed context.
   assign sra  = $signed(a) >>> shamt;
   assign busy = 1'b0;
   assign done = start;

   always_comb begin
      result = a >> shamt;
      if (left)       result = a << shamt;
      else if (arith) result = sra;
   end

`endif

endmodule

// File: rtl/alu_seq_core.sv
// alu_seq_core: collects rs1/rs2 over one bus, executes an RV32I R/I op,
// holds the result on valid/ready. Serial shifts via ALU_SERIAL_SHIFT_EN.
// Ports: clk, rst_n, rs_data/_sel/_valid/_ready, imme_value, op_code,
//   alu_out, alu_valid_out, alu_ready_in, alu_err_out, op_done.
module alu_seq_core
   import alu_pkg::*;
#(
   parameter int BUS = 32,
   parameter int OPCODE = 11,
   localparam int SHAMT_W = $clog2(BUS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BUS-1:0]    rs_data,
   input  logic              rs_data_sel,
   input  logic              rs_data_valid,
   output logic              rs_data_ready,
   input  logic [BUS-1:0]    imme_value,
   input  logic [OPCODE-1:0] op_code,
   output logic [BUS-1:0]    alu_out,
   output logic              alu_valid_out,
   input  logic              alu_ready_in,
   output logic              alu_err_out,
   output logic              op_done
);

   state_e         state_q, state_d;
   logic [BUS-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
   logic [BUS-1:0] imm_q, imm_d, out_q, out_d;
   logic [10:0]    op_q, op_d;
   logic           have_rs1_q, have_rs1_d;
   logic           have_rs2_q, have_rs2_d;
   logic           valid_q, valid_d, err_q, err_d;
   logic           done_q, done_d, ready_q, ready_d;

   logic [6:0]     opc;
   logic [2:0]     f3;
   logic           f7, is_r, bad, need_ok;
   logic           is_shift, exec_fin, cap;
   logic [BUS-1:0] opb, res, sh_res;
   logic           sh_start, sh_busy, sh_done;

   assign opc      = op_opc(op_q);
   assign f3       = op_f3(op_q);
   assign f7       = op_f7b5(op_q);
   assign is_r     = (opc == OPC_R);
   assign bad      = !is_r && (opc != OPC_I);
   assign opb      = is_r ? rs2_q : imm_q;
   assign need_ok  = have_rs1_q && (!is_r || have_rs2_q);
   assign is_shift = !bad && (f3 == F3_SLL || f3 == F3_SR);
   assign sh_start = (state_q == ST_EXEC) && is_shift && !sh_busy;
   assign exec_fin = !is_shift || sh_done;
   assign cap      = rs_data_valid && ready_q;

   alu_shift_unit #(.BUS(BUS)) u_shift (
`ifdef ALU_SERIAL_SHIFT_EN
      .clk    (clk),
      .rst_n  (rst_n),
`endif
      .start  (sh_start),
      .left   (f3 == F3_SLL),
      .arith  (f7),
      .a      (rs1_q),
      .shamt  (opb[SHAMT_W-1:0]),
      .busy   (sh_busy),
      .done   (sh_done),
      .result (sh_res)
   );

   always_comb begin
      res = '0;
      unique case (f3)
         F3_ADD:  res = (is_r && f7) ? rs1_q - opb : rs1_q + opb;
         F3_SLT:  res = BUS'($signed(rs1_q) < $signed(opb));
         F3_SLTU: res = BUS'(rs1_q < opb);
         F3_XOR:  res = rs1_q ^ opb;
         F3_OR:   res = rs1_q | opb;
         F3_AND:  res = rs1_q & opb;
         F3_SLL,
         F3_SR:   res = sh_res;
      endcase
      if (bad) res = '0;
   end

   always_comb begin
      state_d    = state_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      imm_d      = imm_q;
      op_d       = op_q;
      have_rs1_d = have_rs1_q;
      have_rs2_d = have_rs2_q;
      out_d      = out_q;
      err_d      = err_q;
      valid_d    = valid_q;
      done_d     = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_COLLECT: begin
            if (cap && !rs_data_sel) begin
               rs1_d      = rs_data;
               imm_d      = imme_value;
               op_d       = op_code[10:0];
               have_rs1_d = 1'b1;
            end
            if (cap && rs_data_sel) begin
               rs2_d      = rs_data;
               have_rs2_d = 1'b1;
            end
            // Completion is judged on the registered flags, so the
            // hop to EXEC lands one edge after the completing beat.
            if (state_q == ST_IDLE) begin
               if (cap) state_d = ST_COLLECT;
            end else if (need_ok) begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (exec_fin) begin
               out_d   = res;
               err_d   = bad;
               valid_d = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (alu_ready_in) begin
               valid_d    = 1'b0;
               done_d     = 1'b1;
               have_rs1_d = 1'b0;
               have_rs2_d = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_IDLE) || (state_d == ST_COLLECT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rs1_q      <= '0;
         rs2_q      <= '0;
         imm_q      <= '0;
         op_q       <= '0;
         have_rs1_q <= 1'b0;
         have_rs2_q <= 1'b0;
         out_q      <= '0;
         err_q      <= 1'b0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         imm_q      <= imm_d;
         op_q       <= op_d;
         have_rs1_q <= have_rs1_d;
         have_rs2_q <= have_rs2_d;
         out_q      <= out_d;
         err_q      <= err_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         ready_q    <= ready_d;
      end
   end

   assign rs_data_ready = ready_q;
   assign alu_out       = out_q;
   assign alu_valid_out = valid_q;
   assign alu_err_out   = err_q;
   assign op_done       = done_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed stimulus with a result scoreboard for
// alu_seq_core; a negedge monitor pops expectations on each new result.
module tb_alu_seq_core;

   localparam logic [6:0] R = 7'b0110011;
   localparam logic [6:0] I = 7'b0010011;
`ifdef ALU_SERIAL_SHIFT_EN
   localparam bit SER = 1'b1;
`else
   localparam bit SER = 1'b0;
`endif

   typedef struct {
      logic [31:0] out;
      logic        err;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] rs_data;
   logic        rs_data_sel;
   logic        rs_data_valid;
   logic        rs_data_ready;
   logic [31:0] imme_value;
   logic [10:0] op_code;
   logic [31:0] alu_out;
   logic        alu_valid_out;
   logic        alu_ready_in;
   logic        alu_err_out;
   logic        op_done;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   alu_seq_core #(.BUS(32), .OPCODE(11)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rs_data       (rs_data),
      .rs_data_sel   (rs_data_sel),
      .rs_data_valid (rs_data_valid),
      .rs_data_ready (rs_data_ready),
      .imme_value    (imme_value),
      .op_code       (op_code),
      .alu_out       (alu_out),
      .alu_valid_out (alu_valid_out),
      .alu_ready_in  (alu_ready_in),
      .alu_err_out   (alu_err_out),
      .op_done       (op_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [10:0] mk(input bit f7, input bit [2:0] f3,
                                      input bit [6:0] opc);
      return {f7, f3, opc};
   endfunction

   function automatic int sh_lat(input int s);
      if (!SER) return 2;
      return 1 + ((s > 0) ? s : 1);
   endfunction

   initial begin : monitor
      exp_t e;
      bit   seen;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         if (!alu_valid_out) begin
            seen = 1'b0;
         end else if (!seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
               chk("unexpected_result", alu_out, 32'hxxxx_xxxx);
            end else begin
               e = sb.pop_front();
               chk({e.name, "_out"}, alu_out, e.out);
               chk({e.name, "_err"}, {31'd0, alu_err_out}, {31'd0, e.err});
            end
         end
      end
   end

   task automatic send_beat(input bit sel, input logic [31:0] d,
                            input logic [31:0] imm, input logic [10:0] op);
      int n;
      n = 0;
      rs_data_sel   = sel;
      rs_data       = d;
      imme_value    = imm;
      op_code       = op;
      rs_data_valid = 1'b1;
      while (!rs_data_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 50) chk("beat_timeout", n, 0);
      @(posedge clk);
      #1;
      rs_data_valid = 1'b0;
   endtask

   task automatic wait_valid(input string nm, input int lat);
      int n;
      n = 0;
      while (!alu_valid_out && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({nm, "_latency"}, n, lat);
   endtask

   task automatic do_op(input string nm, input int kind,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [10:0] op,
                        input logic [31:0] eo, input logic ee,
                        input int lat);
      exp_t e;
      e.out  = eo;
      e.err  = ee;
      e.name = nm;
      sb.push_back(e);
      case (kind)
         0: send_beat(1'b0, a, imm, op);
         1: begin
            send_beat(1'b0, a, imm, op);
            send_beat(1'b1, b, 32'h0, 11'h7ff);
         end
         2: begin
            send_beat(1'b1, b, 32'h0, 11'h7ff);
            send_beat(1'b0, a, imm, op);
         end
         default: begin
            send_beat(1'b0, 32'd100, imm, op);
            send_beat(1'b0, a, imm, op);
            send_beat(1'b1, b, 32'h0, 11'h7ff);
         end
      endcase
      wait_valid(nm, lat);
      if (alu_ready_in) begin
         @(posedge clk);
         #1;
         chk({nm, "_op_done"}, {31'd0, op_done}, 32'd1);
         chk({nm, "_valid_clr"}, {31'd0, alu_valid_out}, 32'd0);
      end
   endtask

   initial begin : stim
      int cnt;
      rst_n         = 1'b0;
      rs_data       = '0;
      rs_data_sel   = 1'b0;
      rs_data_valid = 1'b0;
      imme_value    = '0;
      op_code       = '0;
      alu_ready_in  = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", alu_out, 0);
      chk("rst_valid", {31'd0, alu_valid_out}, 0);
      chk("rst_err", {31'd0, alu_err_out}, 0);
      chk("rst_done", {31'd0, op_done}, 0);
      chk("rst_ready", {31'd0, rs_data_ready}, 0);
      rst_n = 1'b1;
      #1;
      chk("rel_ready_low", {31'd0, rs_data_ready}, 0);
      @(posedge clk);
      #1;
      chk("rel_ready_high", {31'd0, rs_data_ready}, 1);

      do_op("add", 1, 32'h5, 32'hFFFF_FFFE, 32'h777, mk(0, 3'b000, R),
            32'h3, 1'b0, 2);

      // Abort mid-EXEC: nothing expected from this op.
      send_beat(1'b0, 32'h7, 32'h0, mk(0, 3'b000, R));
      send_beat(1'b1, 32'h8, 32'h0, 11'h7ff);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_out", alu_out, 0);
      chk("abort_valid", {31'd0, alu_valid_out}, 0);
      chk("abort_ready", {31'd0, rs_data_ready}, 0);
      cnt = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (op_done) cnt++;
      end
      chk("abort_no_done", cnt, 0);
      rst_n = 1'b1;
      #1;
      chk("abort_ready_low", {31'd0, rs_data_ready}, 0);
      @(posedge clk);
      #1;
      chk("abort_ready_high", {31'd0, rs_data_ready}, 1);

      alu_ready_in = 1'b0;
      do_op("sub_bp", 2, 32'h3, 32'h5, 32'h777, mk(1, 3'b000, R),
            32'hFFFF_FFFE, 1'b0, 2);
      repeat (4) begin
         @(posedge clk);
         #1;
         chk("bp_hold_out", alu_out, 32'hFFFF_FFFE);
         chk("bp_hold_valid", {31'd0, alu_valid_out}, 1);
         chk("bp_no_done", {31'd0, op_done}, 0);
      end
      alu_ready_in = 1'b1;
      cnt = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (op_done) cnt++;
      end
      chk("bp_done_once", cnt, 1);

      do_op("srai", 0, 32'h8000_0000, 32'h0, 32'h4, mk(1, 3'b101, I),
            32'hF800_0000, 1'b0, sh_lat(4));
      do_op("slt", 1, 32'hFFFF_FFFF, 32'h1, 32'h0, mk(0, 3'b010, R),
            32'h1, 1'b0, 2);
      do_op("sltu", 1, 32'hFFFF_FFFF, 32'h1, 32'h0, mk(0, 3'b011, R),
            32'h0, 1'b0, 2);

      alu_ready_in = 1'b0;
      do_op("badop", 0, 32'h55, 32'h0, 32'h9, mk(0, 3'b000, 7'b0000011),
            32'h0, 1'b1, 2);
      rs_data_sel   = 1'b1;
      rs_data       = 32'h1234;
      rs_data_valid = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("done_ready_low", {31'd0, rs_data_ready}, 0);
         chk("done_err_hold", {31'd0, alu_err_out}, 1);
      end
      rs_data_valid = 1'b0;
      alu_ready_in  = 1'b1;
      @(posedge clk);
      #1;
      chk("badop_op_done", {31'd0, op_done}, 1);

      do_op("xor", 1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h777,
            mk(0, 3'b100, R), 32'h0FF0_0FF0, 1'b0, 2);
      do_op("ori", 0, 32'h0000_0F00, 32'h0, 32'h0000_00FF,
            mk(0, 3'b110, I), 32'h0000_0FFF, 1'b0, 2);
      do_op("andi", 0, 32'h1234_5678, 32'h0, 32'hFFFF_FFF0,
            mk(0, 3'b111, I), 32'h1234_5670, 1'b0, 2);
      do_op("sll_wrap", 1, 32'h1, 32'h21, 32'h777, mk(0, 3'b001, R),
            32'h2, 1'b0, sh_lat(1));
      do_op("srl31", 1, 32'h8000_0000, 32'd31, 32'h777, mk(0, 3'b101, R),
            32'h1, 1'b0, sh_lat(31));
      do_op("srl0", 1, 32'hDEAD_BEEF, 32'h20, 32'h777, mk(0, 3'b101, R),
            32'hDEAD_BEEF, 1'b0, sh_lat(0));
      do_op("addi_f7", 0, 32'd10, 32'h0, 32'd3, mk(1, 3'b000, I),
            32'd13, 1'b0, 2);
      do_op("rs1_rewrite", 3, 32'd9, 32'd1, 32'h777, mk(0, 3'b000, R),
            32'd10, 1'b0, 2);

      repeat (5) @(posedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
